issue_scoreboard_ctrl: RTL
==========================

// Module: issue_scoreboard_ctrl
// PURPOSE
//  In-order issue controller between decode and execute of corev2.
//  - Accepts one decoded instruction (riscv::instr_dec_t) per cycle.
//  - Tracks pending register writes in per-register counters.
//  - Stalls issue on RAW/WAW hazards.
//  - Serialises CSR instructions: drains the pipe, then blocks issue until the CSR op completes.
// PARAMETERS
//  NB_WB_PORTS   2  number of independent writeback ports
//  MAX_INFLIGHT  3  max outstanding writes per register; counter width CW=$clog2(MAX_INFLIGHT+1)
// PORTS
//  clk            in   1             core clock; all state on rising edge
//  reset_n        in   1             asynchronous, active-low reset
//  dec_valid_i    in   1             decode presents an instruction
//  dec_instr_i    in   instr_dec_t   decoded fields (rs1/rs2/rd, *_v, is_csr, ...)
//  dec_ready_o    out  1             controller accepts dec_instr_i this cycle
//  iss_valid_o    out  1             instruction issued to execute
//  iss_ready_i    in   1             execute can accept
//  wb_valid_i     in   NB_WB_PORTS   writeback port k retires a register write
//  wb_rd_i        in   5*NB_WB_PORTS rd of port k, slice [5k+4:5k]
//  csr_done_i     in   1             issued CSR instruction has completed
//  mem_idle_i     in   1             LSU has no outstanding load/store
//  flush_i        in   1             kill all in-flight instructions
//  busy_o         out  1             any register counter non-zero
//  sb_err_o       out  1             sticky: writeback to a register with counter 0
// BEHAVIOUR
//  - Reset: all counters 0; FSM=RUN; sb_err_o=0.
//    While in reset, dec_ready_o=iss_valid_o=0.
//  - Handshake, zero latency, combinational pass-through:
//    - stall = hazard | fsm_block | flush_i.
//    - iss_valid_o = dec_valid_i & ~stall; dec_ready_o = iss_ready_i & ~stall.
//    - fire = dec_valid_i & dec_ready_o.
//  - Hazard:
//    - RAW: (rs1_v & cnt[rs1]!=0) | (rs2_v & cnt[rs2]!=0).
//    - WAW: rd_v & cnt[rd]==MAX_INFLIGHT.
//    - x0 is never tracked: cnt[0] is always 0; rs==0 never causes a hazard.
//  - Counter update per register r, each cycle:
//    - cnt += (fire & rd_v & rd==r & r!=0) - popcount(wb_valid_i[k] & wb_rd_i[k]==r).
//    - Simultaneous issue and writeback on the same r nets out.
//    - Multiple ports writing the same r decrement by the port count.
//    - A decrement below 0 saturates at 0 and sets sb_err_o.
//  - FSM:
//    - RUN:
//      - dec_valid_i & is_csr & (busy_o | ~mem_idle_i): -> DRAIN, fsm_block=1.
//      - is_csr with the pipe idle: may fire in RUN; on fire -> CSR_BUSY.
//    - DRAIN: fsm_block = busy_o | ~mem_idle_i. When the pipe is idle and fire: -> CSR_BUSY.
//    - CSR_BUSY: fsm_block=1; csr_done_i -> RUN. Issue resumes the cycle after csr_done_i.
//    - csr_done_i outside CSR_BUSY is ignored.
//  - Flush:
//    - flush_i blocks fire in the same cycle.
//    - Next cycle: all cnt=0, FSM=RUN, regardless of state.
//    - Writebacks in the flush cycle are discarded (no sb_err_o).
//  - Reset asserted mid-operation returns all state to reset values immediately.
// CONFIGURATION
//  WB_BYPASS_EN:
//    - Defined: RAW/WAW checks use cnt_next (current-cycle writebacks applied).
//      A source whose last pending write retires this cycle issues in the same cycle.
//    - Undefined: checks use registered cnt; the consumer issues one cycle after writeback.
// TESTING
//  1 add x5 issued, then dep add rs1=x5; wb x5 at cycle 3
//    -> BYPASS: dep issues cycle 3; no BYPASS: cycle 4.
//  2 Three writes to x7 outstanding (MAX=3), 4th write to x7 -> stalls until one wb x7; cnt[7] never >3.
//  3 Same-cycle wb port0=x9, port1=x9 with cnt[9]=2 -> cnt[9]=0, busy_o=0, sb_err_o=0.
//  4 CSR with cnt[3]=1 and mem_idle_i=0 -> DRAIN.
//    wb x3 and mem_idle_i=1 -> CSR fires, CSR_BUSY.
//    Next add held until 1 cycle after csr_done_i.
//  5 flush_i in CSR_BUSY with cnt[4]=2 -> next cycle FSM=RUN, busy_o=0; stray wb x4 later -> sb_err_o=1.
//  6 rs1=rs2=x0 with x0 as rd of an in-flight op -> no stall; iss_ready_i=0 -> dec_ready_o=0, no cnt change.

Source files
------------

// File: rtl/issue_scoreboard_ctrl.sv
// In-order issue controller: per-register pending-write scoreboard, RAW/WAW stall, CSR serialisation.
// Optional WB_BYPASS_EN: hazard checks see this cycle's writebacks applied.
package riscv;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_v;
    logic       rs2_v;
    logic       rd_v;
    logic       is_csr;
  } instr_dec_t;
endpackage

module issue_scoreboard_ctrl #(
  parameter int unsigned NB_WB_PORTS  = 2,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dec_valid_i,
  input  riscv::instr_dec_t        dec_instr_i,
  output logic                     dec_ready_o,
  output logic                     iss_valid_o,
  input  logic                     iss_ready_i,
  input  logic [NB_WB_PORTS-1:0]   wb_valid_i,
  input  logic [5*NB_WB_PORTS-1:0] wb_rd_i,
  input  logic                     csr_done_i,
  input  logic                     mem_idle_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  output logic                     sb_err_o
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {StRun, StDrain, StCsrBusy} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q   [32];
  logic [CW-1:0] cnt_d   [32];
  logic [CW-1:0] cnt_chk [32];
  logic [7:0]    wb_dec  [32];
  logic [31:0]   uflow;
  logic          sb_err_q;
  logic          busy;
  logic          raw, waw, hazard, fsm_block, stall, fire;
  logic [7:0]    cnt_ext;

  // Writeback decrements per register; x0 is never tracked.
  always_comb begin
    cnt_ext = '0;
    for (int r = 0; r < 32; r++) begin
      wb_dec[r] = '0;
      for (int k = 0; k < int'(NB_WB_PORTS); k++) begin
        if (wb_valid_i[k] && wb_rd_i[5*k +: 5] == 5'(r) && r != 0) begin
          wb_dec[r] = wb_dec[r] + 8'd1;
        end
      end
      cnt_ext = 8'(cnt_q[r]);
`ifdef WB_BYPASS_EN
      cnt_chk[r] = (cnt_ext >= wb_dec[r]) ? CW'(cnt_ext - wb_dec[r]) : '0;
`else
      cnt_chk[r] = cnt_q[r];
`endif
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < 32; r++) begin
      busy = busy | (cnt_q[r] != '0);
    end
  end

  always_comb begin
    raw = (dec_instr_i.rs1_v && dec_instr_i.rs1 != 5'd0 && cnt_chk[dec_instr_i.rs1] != '0) ||
          (dec_instr_i.rs2_v && dec_instr_i.rs2 != 5'd0 && cnt_chk[dec_instr_i.rs2] != '0);
    waw = dec_instr_i.rd_v && dec_instr_i.rd != 5'd0 &&
          cnt_chk[dec_instr_i.rd] == CW'(MAX_INFLIGHT);
    hazard = raw | waw;
  end

  always_comb begin
    unique case (state_q)
      StRun:     fsm_block = dec_valid_i & dec_instr_i.is_csr & (busy | ~mem_idle_i);
      StDrain:   fsm_block = busy | ~mem_idle_i;
      StCsrBusy: fsm_block = 1'b1;
      default:   fsm_block = 1'b1;
    endcase
  end

  // Reset is folded into stall so nothing handshakes while reset is held.
  assign stall       = hazard | fsm_block | flush_i | ~reset_n;
  assign iss_valid_o = dec_valid_i & ~stall;
  assign dec_ready_o = iss_ready_i & ~stall;
  assign fire        = dec_valid_i & dec_ready_o;
  assign busy_o      = busy;
  assign sb_err_o    = sb_err_q;

  // Net issue/writeback update; underflow saturates at zero and is reported.
  always_comb begin
    logic [7:0] sum;
    sum   = '0;
    uflow = '0;
    for (int r = 0; r < 32; r++) begin
      sum = 8'(cnt_q[r]);
      if (fire && dec_instr_i.rd_v && dec_instr_i.rd == 5'(r) && r != 0) begin
        sum = sum + 8'd1;
      end
      if (sum < wb_dec[r]) begin
        cnt_d[r] = '0;
        uflow[r] = 1'b1;
      end else begin
        cnt_d[r] = CW'(sum - wb_dec[r]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StRun;
      sb_err_q <= 1'b0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else if (flush_i) begin
      state_q <= StRun;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      if (uflow != '0) sb_err_q <= 1'b1;
      unique case (state_q)
        StRun: begin
          if (fire && dec_instr_i.is_csr) state_q <= StCsrBusy;
          else if (fsm_block)             state_q <= StDrain;
        end
        StDrain: begin
          if (fire) state_q <= StCsrBusy;
        end
        StCsrBusy: begin
          if (csr_done_i) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
